add_round_key_stage: RTL and testbench

ADD_ROUND_KEY_STAGE -- requirements
Module: add_round_key_stage

---
 rtl/ark_pkg.sv | 21 ++
 rtl/ark_fifo.sv | 62 ++++++
 rtl/add_round_key_stage.sv | 104 ++++++++++
 tb/tb_add_round_key_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ark_pkg.sv
// Shared defaults, index-width helper and packet layout for the add-round-key stage.
package ark_pkg;

   localparam int DATA_W_DEF     = 128;
   localparam int HDR_W_DEF      = 4;
   localparam int NUM_KEYS_DEF   = 11;
   localparam int FIFO_DEPTH_DEF = 4;

   // A single-entry table still needs a one-bit index port.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W_DEF = idx_w(NUM_KEYS_DEF);

   typedef struct packed {
      logic [HDR_W_DEF-1:0]  hdr;
      logic [DATA_W_DEF-1:0] payload;
   } ark_pkt_t;

endpackage

// File: rtl/ark_fifo.sv
// Generic synchronous FIFO: head visible combinationally, one cycle after the push edge.
// Pushes while full and pops while empty are ignored; the caller gates on full/empty.
module ark_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (cnt == FULL_CNT);
   assign empty    = (cnt == '0);
   assign count    = cnt;
   assign pop_data = mem[rd_ptr];
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;

   // Depth is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + CNT_ONE;
            2'b01:   cnt <= cnt - CNT_ONE;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/add_round_key_stage.sv
// XORs each packet payload with a selected round key and buffers it; 1-cycle latency into an empty buffer.
// in_ready drops only when the buffer is full; header-zero and bad-index packets are consumed and dropped.
module add_round_key_stage
   import ark_pkg::*;
#(
   parameter  int DATA_W     = DATA_W_DEF,
   parameter  int HDR_W      = HDR_W_DEF,
   parameter  int NUM_KEYS   = NUM_KEYS_DEF,
   parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int IDX_W      = idx_w(NUM_KEYS),
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    key_wr_en,
   input  logic [IDX_W-1:0]        key_wr_idx,
   input  logic [DATA_W-1:0]       key_wr_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [HDR_W+DATA_W-1:0] in_data,
   input  logic [IDX_W-1:0]        in_key_idx,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [HDR_W+DATA_W-1:0] out_data,
   output logic                    err_bad_idx,
   output logic [CNT_W-1:0]        fill_level
);

   typedef struct packed {
      logic [HDR_W-1:0]  hdr;
      logic [DATA_W-1:0] payload;
   } pkt_t;

   localparam logic [IDX_W:0] KEY_LIMIT = (IDX_W+1)'(NUM_KEYS);

   logic [DATA_W-1:0] key_table [NUM_KEYS];
   logic [DATA_W-1:0] sel_key;
   pkt_t              in_pkt;
   pkt_t              xor_pkt;
   logic              in_idx_ok;
   logic              wr_idx_ok;
   logic              accept;
   logic              hdr_zero;
   logic              push;
   logic              full;
   logic              empty;

   assign in_pkt    = in_data;
   assign in_idx_ok = ({1'b0, in_key_idx} < KEY_LIMIT);
   assign wr_idx_ok = ({1'b0, key_wr_idx} < KEY_LIMIT);
   assign hdr_zero  = (in_pkt.hdr == '0);
   assign accept    = in_valid && in_ready;
   assign push      = accept && !hdr_zero && in_idx_ok;

   // Table is read combinationally from registered state, so a same-cycle key write is seen only by later packets.
   always_comb begin
      sel_key = '0;
      if (in_idx_ok) begin
         sel_key = key_table[in_key_idx];
      end
   end

   always_comb begin
      xor_pkt         = in_pkt;
      xor_pkt.payload = in_pkt.payload ^ sel_key;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            key_table[i] <= '0;
         end
      end else if (key_wr_en && wr_idx_ok) begin
         key_table[key_wr_idx] <= key_wr_data;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         err_bad_idx <= 1'b0;
      end else begin
         err_bad_idx <= accept && !hdr_zero && !in_idx_ok;
      end
   end

   ark_fifo #(
      .WIDTH (HDR_W + DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .n_rst     (n_rst),
      .push      (push),
      .push_data (xor_pkt),
      .pop       (out_ready),
      .pop_data  (out_data),
      .full      (full),
      .empty     (empty),
      .count     (fill_level)
   );

   assign in_ready  = !full;
   assign out_valid = !empty;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed bench for add_round_key_stage at default parameters.
module tb_add_round_key_stage;
   import ark_pkg::*;

   logic           clk;
   logic           n_rst;
   logic           key_wr_en;
   logic [3:0]     key_wr_idx;
   logic [127:0]   key_wr_data;
   logic           in_valid;
   logic           in_ready;
   logic [131:0]   in_data;
   logic [3:0]     in_key_idx;
   logic           out_valid;
   logic           out_ready;
   logic [131:0]   out_data;
   logic           err_bad_idx;
   logic [2:0]     fill_level;

   int checks;
   int errors;

   localparam logic [127:0] K0     = {32{4'hA}};
   localparam logic [127:0] K1     = 128'h0123456789abcdef_fedcba9876543210;
   localparam logic [127:0] K2_OLD = {32{4'h1}};
   localparam logic [127:0] K2_NEW = {32{4'h2}};
   localparam logic [127:0] K3     = {128{1'b1}};
   localparam logic [127:0] P0F    = {16{8'h0F}};

   add_round_key_stage dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .key_wr_en   (key_wr_en),
      .key_wr_idx  (key_wr_idx),
      .key_wr_data (key_wr_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_key_idx  (in_key_idx),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .err_bad_idx (err_bad_idx),
      .fill_level  (fill_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   hdr;
      logic [127:0] pay;
      logic [3:0]   idx;
      bit           exp_out;
      bit           exp_err;
      logic [127:0] exp_pay;
   } vec_t;

   vec_t vecs [8];

   task automatic chk_num(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic chk_vec(input string name, input logic [131:0] act, input logic [131:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic key_write(input logic [3:0] idx, input logic [127:0] data);
      key_wr_en   = 1'b1;
      key_wr_idx  = idx;
      key_wr_data = data;
      step();
      key_wr_en   = 1'b0;
   endtask

   task automatic drive_pkt(input logic [3:0] hdr, input logic [127:0] pay, input logic [3:0] idx);
      in_valid   = 1'b1;
      in_data    = {hdr, pay};
      in_key_idx = idx;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      n_rst       = 1'b0;
      key_wr_en   = 1'b0;
      key_wr_idx  = '0;
      key_wr_data = '0;
      in_valid    = 1'b0;
      in_data     = '0;
      in_key_idx  = '0;
      out_ready   = 1'b1;

      vecs[0] = '{4'h5, P0F,                                   4'd3,  1'b1, 1'b0, {16{8'hF0}}};
      vecs[1] = '{4'h0, P0F,                                   4'd3,  1'b0, 1'b0, '0};
      vecs[2] = '{4'h1, P0F,                                   4'd11, 1'b0, 1'b1, '0};
      vecs[3] = '{4'hF, 128'h1234,                             4'd15, 1'b0, 1'b1, '0};
      vecs[4] = '{4'hA, 128'hffffffff_00000000_ffffffff_00000000, 4'd1, 1'b1, 1'b0,
                  128'hfedcba98_89abcdef_01234567_76543210};
      vecs[5] = '{4'h3, {32{4'h5}},                            4'd0,  1'b1, 1'b0, {128{1'b1}}};
      vecs[6] = '{4'h0, P0F,                                   4'd11, 1'b0, 1'b0, '0};
      vecs[7] = '{4'h2, 128'hc0ffee,                           4'd10, 1'b1, 1'b0, 128'hc0ffee};

      #1;
      chk_num("rst_out_valid", int'(out_valid), 0);
      chk_num("rst_fill", int'(fill_level), 0);
      chk_num("rst_err", int'(err_bad_idx), 0);
      step();
      step();
      n_rst = 1'b1;
      step();
      chk_num("post_rst_in_ready", int'(in_ready), 1);

      key_write(4'd0, K0);
      key_write(4'd1, K1);
      key_write(4'd2, K2_OLD);
      key_write(4'd3, K3);
      key_write(4'd11, {128{1'b1}});
      key_write(4'd15, {128{1'b1}});

      foreach (vecs[i]) begin
         chk_num($sformatf("v%0d_in_ready", i), int'(in_ready), 1);
         drive_pkt(vecs[i].hdr, vecs[i].pay, vecs[i].idx);
         step();
         in_valid = 1'b0;
         chk_num($sformatf("v%0d_out_valid", i), int'(out_valid), int'(vecs[i].exp_out));
         chk_num($sformatf("v%0d_err", i), int'(err_bad_idx), int'(vecs[i].exp_err));
         chk_num($sformatf("v%0d_in_ready_after", i), int'(in_ready), 1);
         if (vecs[i].exp_out) begin
            chk_vec($sformatf("v%0d_out_data", i), out_data, {vecs[i].hdr, vecs[i].exp_pay});
         end
         step();
         chk_num($sformatf("v%0d_err_cleared", i), int'(err_bad_idx), 0);
         chk_num($sformatf("v%0d_drained", i), int'(out_valid), 0);
      end

      // Fill to capacity with the consumer stalled, then drain.
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive_pkt(4'(i), 128'(i * 16), 4'd10);
         step();
         chk_num($sformatf("fill_after_push%0d", i), int'(fill_level), i);
      end
      chk_num("full_in_ready", int'(in_ready), 0);
      drive_pkt(4'd5, 128'h50, 4'd10);
      step();
      chk_num("full_hold_fill", int'(fill_level), 4);
      chk_vec("full_hold_head", out_data, {4'd1, 128'h10});
      out_ready = 1'b1;
      step();
      chk_num("pop1_fill", int'(fill_level), 3);
      chk_num("pop1_in_ready", int'(in_ready), 1);
      chk_vec("pop1_head", out_data, {4'd2, 128'h20});
      step();
      in_valid = 1'b0;
      chk_num("push_pop_fill", int'(fill_level), 3);
      for (int i = 3; i <= 5; i++) begin
         chk_vec($sformatf("drain_head%0d", i), out_data, {4'(i), 128'(i * 16)});
         step();
      end
      chk_num("drain_empty", int'(out_valid), 0);
      chk_num("drain_fill", int'(fill_level), 0);

      // Key write and packet on the same slot in the same cycle.
      key_wr_en   = 1'b1;
      key_wr_idx  = 4'd2;
      key_wr_data = K2_NEW;
      drive_pkt(4'd6, '0, 4'd2);
      step();
      key_wr_en = 1'b0;
      drive_pkt(4'd7, '0, 4'd2);
      chk_vec("same_cycle_old_key", out_data, {4'd6, K2_OLD});
      step();
      in_valid = 1'b0;
      chk_vec("next_pkt_new_key", out_data, {4'd7, K2_NEW});
      step();
      chk_num("key_seq_empty", int'(out_valid), 0);

      // Asynchronous reset with three entries buffered.
      out_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         drive_pkt(4'(i), P0F, 4'd3);
         step();
      end
      in_valid = 1'b0;
      chk_num("pre_rst_fill", int'(fill_level), 3);
      #2;
      n_rst = 1'b0;
      #1;
      chk_num("async_rst_out_valid", int'(out_valid), 0);
      chk_num("async_rst_fill", int'(fill_level), 0);
      #3;
      n_rst = 1'b1;
      step();
      chk_num("rst2_in_ready", int'(in_ready), 1);
      out_ready = 1'b1;
      drive_pkt(4'd5, P0F, 4'd3);
      step();
      drive_pkt(4'd9, K1, 4'd1);
      chk_vec("rst_key3_zero", out_data, {4'd5, P0F});
      step();
      in_valid = 1'b0;
      chk_vec("rst_key1_zero", out_data, {4'd9, K1});
      step();
      chk_num("final_empty", int'(out_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
